perceptron_train_seq: RTL and testbench

Sequencer that runs one training or inference step of the two-input perceptron for each sample it accepts. It sits between a sample source (host link or on-chip sample memory) and the perceptron datapath. For each sample it loads the inputs, waits for the neuron result, and classifies. When training is enabled and the sample is misclassified, it computes and writes back updated weights using the perceptron learning rule.

---
 rtl/perceptron_pkg.sv | 35 +++
 rtl/perceptron_train_seq_weight_update.sv | 34 +++
 rtl/perceptron_train_seq.sv | 134 +++++++++++++
 tb/tb_perceptron_train_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron training sequencer.
// PERCEPTRON_SAT_EN selects saturating weight updates (see sat_add).
package perceptron_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned WIDE_W     = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_EVAL,
    S_UPDATE
  } state_t;

  localparam logic CLASS_POS = 1'b1;
  localparam logic CLASS_NEG = 1'b0;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Operands arrive sign-extended to WIDE_W, so their sum cannot overflow.
  // It is clamped to the signed range of a w-bit word.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    wide_t s;
    wide_t max_v;
    wide_t min_v;
    s     = a + b;
    max_v = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    min_v = -(wide_t'(1) <<< (w - 1));
    if (s > max_v)      sat_add = max_v;
    else if (s < min_v) sat_add = min_v;
    else                sat_add = s;
  endfunction

endpackage

// File: rtl/perceptron_train_seq_weight_update.sv
// Combinational perceptron learning-rule update for a single weight.
// PERCEPTRON_SAT_EN selects saturation instead of modulo-2^DATA_W wrap.
module perceptron_weight_update
  import perceptron_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LR_SHIFT = 4
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  input  logic              target,
  input  logic              err,
  output logic [DATA_W-1:0] w_new
);

  logic signed [DATA_W-1:0] d;
  logic        [DATA_W-1:0] w_upd;

  assign d = $signed(x) >>> LR_SHIFT;

`ifdef PERCEPTRON_SAT_EN
  wide_t w_wide;
  wide_t d_wide;
  assign w_wide = {{(WIDE_W-DATA_W){w[DATA_W-1]}}, w};
  assign d_wide = {{(WIDE_W-DATA_W){d[DATA_W-1]}}, d};
  assign w_upd  = DATA_W'(sat_add(w_wide, (target == CLASS_POS) ? d_wide : -d_wide, DATA_W));
`else
  // A DATA_W-bit add/sub yields exactly the low DATA_W bits of the wide sum.
  assign w_upd = (target == CLASS_POS) ? (w + d) : (w - d);
`endif

  assign w_new = err ? w_upd : w;

endmodule

// File: rtl/perceptron_train_seq.sv
// Sequencer running one train/inference step of a two-input perceptron per sample.
// Build option: PERCEPTRON_SAT_EN (saturating weight update, else wrap).
module perceptron_train_seq
  import perceptron_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned LR_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic              target,
  input  logic              train_en,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] weight1,
  input  logic [DATA_W-1:0] weight2,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] data_in1,
  output logic [DATA_W-1:0] data_in2,
  output logic              input_write,
  output logic [DATA_W-1:0] weight1_new,
  output logic [DATA_W-1:0] weight2_new,
  output logic              weight_write,
  output logic              pred,
  output logic              pred_valid,
  output logic              done,
  output logic [15:0]       err_cnt
);

  state_t            state;
  logic [3:0]        lat_cnt;
  logic              target_q;
  logic              train_q;
  logic              err_q;
  logic              pred_next;
  logic              err_next;
  logic              eval_entry;
  logic [DATA_W-1:0] w1_calc;
  logic [DATA_W-1:0] w2_calc;

  assign pred_next = ($signed(result) >= 0);
  assign err_next  = (pred_next != target_q);

  // EVAL is entered once LATENCY-1 WAIT cycles have elapsed; with LATENCY=1 straight from APPLY.
  always_comb begin
    eval_entry = 1'b0;
    if (state == S_APPLY && LATENCY == 1)    eval_entry = 1'b1;
    if (state == S_WAIT  && lat_cnt == 4'd1) eval_entry = 1'b1;
  end

  perceptron_weight_update #(.DATA_W(DATA_W), .LR_SHIFT(LR_SHIFT)) u_upd1 (
    .x(data_in1), .w(weight1), .target(target_q), .err(err_next), .w_new(w1_calc)
  );

  perceptron_weight_update #(.DATA_W(DATA_W), .LR_SHIFT(LR_SHIFT)) u_upd2 (
    .x(data_in2), .w(weight2), .target(target_q), .err(err_next), .w_new(w2_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      target_q     <= 1'b0;
      train_q      <= 1'b0;
      err_q        <= 1'b0;
      sample_ready <= 1'b1;
      data_in1     <= '0;
      data_in2     <= '0;
      input_write  <= 1'b0;
      weight1_new  <= '0;
      weight2_new  <= '0;
      weight_write <= 1'b0;
      pred         <= 1'b0;
      pred_valid   <= 1'b0;
      done         <= 1'b0;
      err_cnt      <= '0;
    end else begin
      input_write  <= 1'b0;
      pred_valid   <= 1'b0;
      done         <= 1'b0;
      weight_write <= 1'b0;

      if (clr_err)
        err_cnt <= '0;
      else if (state == S_UPDATE && err_q && err_cnt != '1)
        err_cnt <= err_cnt + 16'd1;

      if (eval_entry) begin
        state       <= S_EVAL;
        pred        <= pred_next;
        pred_valid  <= 1'b1;
        err_q       <= err_next;
        weight1_new <= w1_calc;
        weight2_new <= w2_calc;
      end else begin
        case (state)
          S_IDLE: begin
            if (sample_valid) begin
              data_in1     <= x1;
              data_in2     <= x2;
              target_q     <= target;
              train_q      <= train_en;
              sample_ready <= 1'b0;
              input_write  <= 1'b1;
              state        <= S_APPLY;
            end
          end
          S_APPLY: begin
            lat_cnt <= 4'(LATENCY - 1);
            state   <= S_WAIT;
          end
          S_WAIT: begin
            lat_cnt <= lat_cnt - 4'd1;
          end
          S_EVAL: begin
            done         <= 1'b1;
            weight_write <= err_q & train_q;
            state        <= S_UPDATE;
          end
          S_UPDATE: begin
            sample_ready <= 1'b1;
            state        <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perceptron_train_seq.sv
// Directed and randomized bench for perceptron_train_seq against an arithmetic model.
module tb_perceptron_train_seq;

  localparam int unsigned DW   = 16;
  localparam int unsigned L    = 2;
  localparam int unsigned LRS  = 4;
  localparam int unsigned STEP = L + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_valid;
  logic          sample_ready;
  logic [DW-1:0] x1, x2;
  logic          target, train_en, clr_err;
  logic [DW-1:0] weight1, weight2, result;
  logic [DW-1:0] data_in1, data_in2;
  logic          input_write;
  logic [DW-1:0] weight1_new, weight2_new;
  logic          weight_write, pred, pred_valid, done;
  logic [15:0]   err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int model_cnt = 0;

  perceptron_train_seq #(.DATA_W(DW), .LATENCY(L), .LR_SHIFT(LRS)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .x1(x1), .x2(x2), .target(target), .train_en(train_en), .clr_err(clr_err),
    .weight1(weight1), .weight2(weight2), .result(result),
    .data_in1(data_in1), .data_in2(data_in2), .input_write(input_write),
    .weight1_new(weight1_new), .weight2_new(weight2_new), .weight_write(weight_write),
    .pred(pred), .pred_valid(pred_valid), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Learning rule in plain integer arithmetic.
  function automatic logic [DW-1:0] wt_model(input logic [DW-1:0] w, input logic [DW-1:0] x,
                                              input bit tgt, input bit err);
    int wi, xi, di, s;
    wi = int'($signed(w));
    xi = int'($signed(x));
    di = xi >>> LRS;
    if (!err) return w;
    s = tgt ? wi + di : wi - di;
`ifdef PERCEPTRON_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return DW'(s);
  endfunction

  task automatic run_step(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] r, input logic [DW-1:0] wa, input logic [DW-1:0] wb,
                          input bit tgt, input bit ten, input bit clr);
    logic [7:0] iw_v, pv_v, dn_v, ww_v, rdy_v;
    bit pr, er;
    int guard;
    @(negedge clk);
    x1 = a; x2 = b; result = r; weight1 = wa; weight2 = wb;
    target = tgt; train_en = ten; clr_err = clr; sample_valid = 1'b1;
    guard = 0;
    while (!sample_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      sample_valid = 1'b0;
      return;
    end
    pr = ~r[DW-1];
    er = (pr != tgt);
    if (clr) model_cnt = 0;
    else if (er && model_cnt != 16'hFFFF) model_cnt++;
    iw_v = '0; pv_v = '0; dn_v = '0; ww_v = '0; rdy_v = '0;
    for (int k = 1; k <= int'(STEP); k++) begin
      @(negedge clk);
      if (k == 1) sample_valid = 1'b0;
      iw_v[k-1]  = input_write;
      pv_v[k-1]  = pred_valid;
      dn_v[k-1]  = done;
      ww_v[k-1]  = weight_write;
      rdy_v[k-1] = sample_ready;
      if (k == 1) begin
        chk({tag, "_data_in1"}, data_in1, a);
        chk({tag, "_data_in2"}, data_in2, b);
      end
      if (k == int'(L) + 1) chk({tag, "_pred"}, pred, pr);
      if (k == int'(L) + 2) begin
        chk({tag, "_w1_new"}, weight1_new, wt_model(wa, a, tgt, er));
        chk({tag, "_w2_new"}, weight2_new, wt_model(wb, b, tgt, er));
      end
      if (k == int'(STEP)) chk({tag, "_err_cnt"}, err_cnt, model_cnt);
    end
    chk({tag, "_input_write_seq"}, iw_v, 8'h01);
    chk({tag, "_pred_valid_seq"}, pv_v, 8'h01 << L);
    chk({tag, "_done_seq"}, dn_v, 8'h01 << (L + 1));
    chk({tag, "_weight_write_seq"}, ww_v, (er && ten) ? (8'h01 << (L + 1)) : 8'h00);
    chk({tag, "_ready_seq"}, rdy_v, 8'h01 << (L + 2));
    clr_err = 1'b0;
  endtask

  initial begin
    int acc_cyc [4];
    int n_acc, rdy_between, guard;
    logic [7:0] rdy_hist [32];
    logic any_strobe;

    rst_n = 1'b0; sample_valid = 1'b0; x1 = '0; x2 = '0; target = 1'b0;
    train_en = 1'b0; clr_err = 1'b0; weight1 = '0; weight2 = '0; result = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", sample_ready, 1);
    chk("rst_strobes", {input_write, pred_valid, done, weight_write}, 4'b0000);
    chk("rst_pred", pred, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_data_in", {data_in1, data_in2}, 32'h0);
    chk("rst_w_new", {weight1_new, weight2_new}, 32'h0);
    rst_n = 1'b1;

    run_step("miss_upd", 16'h0100, 16'hFF00, 16'h8000, 16'h0010, 16'h0020, 1, 1, 0);
    chk("miss_upd_w1_abs", weight1_new, 16'h0020);
    chk("miss_upd_w2_abs", weight2_new, 16'h0010);
    run_step("correct", 16'h0100, 16'hFF00, 16'h0005, 16'h0010, 16'h0020, 1, 1, 0);
    run_step("overflow", 16'h7FFF, 16'h0000, 16'h8000, 16'h7FF0, 16'h0000, 1, 1, 0);
`ifdef PERCEPTRON_SAT_EN
    chk("overflow_abs", weight1_new, 16'h7FFF);
`else
    chk("overflow_abs", weight1_new, 16'h87EF);
`endif
    run_step("infer_miss", 16'h1234, 16'h0042, 16'h0001, 16'h0100, 16'h0200, 0, 0, 0);

    @(negedge clk);
    force dut.err_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt;
    model_cnt = 16'hFFFF;
    chk("preset_err_cnt", err_cnt, 16'hFFFF);
    run_step("sat_cnt", 16'h0040, 16'h0040, 16'h0001, 16'h0000, 16'h0000, 0, 1, 0);
    run_step("clr_miss", 16'h0040, 16'h0040, 16'h0001, 16'h0000, 16'h0000, 0, 1, 1);

    for (int i = 0; i < 40; i++) begin
      run_step("rand", DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end

    // Back-to-back: valid held for three accepts.
    @(negedge clk);
    x1 = 16'h0011; x2 = 16'h0022; result = 16'h0005; target = 1'b1; train_en = 1'b1;
    sample_valid = 1'b1;
    n_acc = 0;
    for (int c = 0; c < int'(3 * STEP + 4); c++) begin
      rdy_hist[c] = {7'b0, sample_ready};
      if (n_acc == 3 && !sample_ready) sample_valid = 1'b0;
      if (sample_valid && sample_ready && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("b2b_accepts", n_acc, 3);
    if (n_acc == 3) begin
      chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], STEP);
      chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], STEP);
      rdy_between = 0;
      for (int c = acc_cyc[0] + 1; c < acc_cyc[2]; c++) rdy_between += int'(rdy_hist[c]);
      chk("b2b_ready_between", rdy_between, 1);
    end
    chk("b2b_err_cnt", err_cnt, model_cnt);

    // Reset asserted while the step sits in WAIT.
    @(negedge clk);
    x1 = 16'h0100; x2 = 16'h0100; result = 16'h8000; target = 1'b1; train_en = 1'b1;
    sample_valid = 1'b1;
    guard = 0;
    while (!sample_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_cnt = 0;
    #1;
    chk("midrst_ready", sample_ready, 1);
    chk("midrst_strobes", {input_write, pred_valid, done, weight_write}, 4'b0000);
    chk("midrst_pred_cnt", {15'b0, pred, err_cnt}, 32'h0);
    chk("midrst_data_in", {data_in1, data_in2}, 32'h0);
    chk("midrst_w_new", {weight1_new, weight2_new}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    any_strobe = 1'b0;
    for (int c = 0; c < int'(STEP + 2); c++) begin
      @(negedge clk);
      any_strobe = any_strobe | weight_write | done | pred_valid | input_write;
    end
    chk("midrst_no_strobe", any_strobe, 0);
    chk("midrst_idle", sample_ready, 1);
    run_step("post_rst", 16'h0100, 16'hFF00, 16'h8000, 16'h0010, 16'h0020, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
